gpr_file_param: RTL and testbench

- Parametrised general-purpose register file; next generation of the board-level GPR block.
- Configurable data width, depth and read-port count.
- Adds registered (1-cycle) reads, write-to-read bypass, optional hardwired-zero register 0, and a hardware clear sequencer that zeroes the array after reset or on request.
- Sits between the datapath/switch front-end and display/ALU consumers; `ready` gates all traffic.

---
 rtl/gpr_file_param.sv | 128 ++++++++++++
 tb/tb_gpr_file_param.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gpr_file_param.sv
// Parametrised general-purpose register file with registered multi-port reads,
// write-first bypass, optional hardwired-zero r0 and a clear sweep after reset or on request.
module gpr_file_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_valid,
  input  logic                       init_req,
  output logic                       ready
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                ready_q, ready_d;
  logic                wr_fire_c;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_val_c [NUM_RD];

  assign ready = ready_q;

  // State, sweep counter and ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state: sweep every entry once, then serve traffic until init_req.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    case (state_q)
      ST_INIT: begin
        ready_d   = 1'b0;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d   = ST_READY;
          clr_cnt_d = '0;
          ready_d   = 1'b1;
        end
      end
      ST_READY: begin
        ready_d = 1'b1;
        if (init_req) begin
          state_d   = ST_INIT;
          clr_cnt_d = '0;
          ready_d   = 1'b0;
        end
      end
      default: begin
        state_d   = ST_INIT;
        clr_cnt_d = '0;
        ready_d   = 1'b0;
      end
    endcase
  end

  // Writes to r0 are dropped when it is hardwired to zero.
  assign wr_fire_c = (state_q == ST_READY) && wr_en &&
                     !(ZERO_REG && (wr_addr == '0));

  // Storage has no reset; the sweep owns the write port while clearing.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_fire_c) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Per-port read value with write-first bypass and zero override.
  always_comb begin
    for (int p = 0; p < int'(NUM_RD); p++) begin
      rd_val_c[p] = mem[rd_addr[p*ADDR_W +: ADDR_W]];
      if (wr_fire_c && (wr_addr == rd_addr[p*ADDR_W +: ADDR_W])) begin
        rd_val_c[p] = wr_data;
      end
      if (ZERO_REG && (rd_addr[p*ADDR_W +: ADDR_W] == '0)) begin
        rd_val_c[p] = '0;
      end
    end
  end

  // Registered read outputs; data holds when a port is idle in READY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      for (int p = 0; p < int'(NUM_RD); p++) begin
        if (state_q != ST_READY) begin
          rd_data[p*DATA_W +: DATA_W] <= '0;
          rd_valid[p]                 <= 1'b0;
        end else if (rd_en[p]) begin
          rd_data[p*DATA_W +: DATA_W] <= rd_val_c[p];
          rd_valid[p]                 <= 1'b1;
        end else begin
          rd_valid[p]                 <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gpr_file_param.sv
// Directed bench for gpr_file_param: default 32x32/2-port/zero-r0 instance
// plus an 8x8/3-port instance with an ordinary r0.
module tb_gpr_file_param;

  logic        clk;
  logic        rst_n, rst_n_b;

  // Instance A: DATA_W=32, ADDR_W=5, NUM_RD=2, ZERO_REG=1
  logic        wr_en_a;
  logic [4:0]  wr_addr_a;
  logic [31:0] wr_data_a;
  logic [1:0]  rd_en_a;
  logic [9:0]  rd_addr_a;
  logic [63:0] rd_data_a;
  logic [1:0]  rd_valid_a;
  logic        init_req_a;
  logic        ready_a;

  // Instance B: DATA_W=8, ADDR_W=3, NUM_RD=3, ZERO_REG=0
  logic        wr_en_b;
  logic [2:0]  wr_addr_b;
  logic [7:0]  wr_data_b;
  logic [2:0]  rd_en_b;
  logic [8:0]  rd_addr_b;
  logic [23:0] rd_data_b;
  logic [2:0]  rd_valid_b;
  logic        init_req_b;
  logic        ready_b;

  int checks;
  int failures;
  int n;

  gpr_file_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .init_req(init_req_a), .ready(ready_a)
  );

  gpr_file_param #(.DATA_W(8), .ADDR_W(3), .NUM_RD(3), .ZERO_REG(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .init_req(init_req_b), .ready(ready_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change at negedge; outputs are observed at the following negedge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic count_low_a(output int cnt);
    cnt = 0;
    while (!ready_a && cnt < 200) begin
      cnt++;
      step();
    end
  endtask

  task automatic count_low_b(output int cnt);
    cnt = 0;
    while (!ready_b && cnt < 200) begin
      cnt++;
      step();
    end
  endtask

  task automatic write_a(input logic [4:0] a, input logic [31:0] d);
    wr_en_a = 1'b1; wr_addr_a = a; wr_data_a = d;
    step();
    wr_en_a = 1'b0;
  endtask

  task automatic read_a(input logic [4:0] a0, input logic [4:0] a1);
    rd_en_a = 2'b11; rd_addr_a = {a1, a0};
    step();
    rd_en_a = 2'b00;
  endtask

  initial begin
    checks = 0; failures = 0;
    clk = 1'b0; rst_n = 1'b0; rst_n_b = 1'b0;
    wr_en_a = 0; wr_addr_a = '0; wr_data_a = '0; rd_en_a = '0; rd_addr_a = '0; init_req_a = 0;
    wr_en_b = 0; wr_addr_b = '0; wr_data_b = '0; rd_en_b = '0; rd_addr_b = '0; init_req_b = 0;

    step(); step();
    chk("rst_ready", 64'(ready_a), 64'd0);
    chk("rst_rd_data", rd_data_a, 64'd0);
    chk("rst_rd_valid", 64'(rd_valid_a), 64'd0);

    // Power-up sweep: 32 cycles with ready low
    rst_n = 1'b1;
    count_low_a(n);
    chk("init_len", 64'(n), 64'd32);
    chk("init_rd_valid", 64'(rd_valid_a), 64'd0);

    for (int i = 0; i < 32; i++) begin
      read_a(5'(i), 5'(31 - i));
      chk("clear_read", rd_data_a, 64'd0);
      chk("clear_valid", 64'(rd_valid_a), 64'd3);
    end

    // Write then dual-port read of r5
    write_a(5'd5, 32'hDEADBEEF);
    read_a(5'd5, 5'd5);
    chk("r5_dual", rd_data_a, 64'hDEADBEEF_DEADBEEF);
    chk("r5_valid", 64'(rd_valid_a), 64'd3);

    // Bypass on r7, port 1 idle holds its data
    wr_en_a = 1'b1; wr_addr_a = 5'd7; wr_data_a = 32'h12345678;
    rd_en_a = 2'b01; rd_addr_a = {5'd0, 5'd7};
    step();
    wr_en_a = 1'b0; rd_en_a = 2'b00;
    chk("bypass_r7", rd_data_a, 64'hDEADBEEF_12345678);
    chk("bypass_valid", 64'(rd_valid_a), 64'd1);
    step();
    chk("idle_valid", 64'(rd_valid_a), 64'd0);
    chk("idle_hold", rd_data_a, 64'hDEADBEEF_12345678);

    // Bypass attempt on hardwired r0
    wr_en_a = 1'b1; wr_addr_a = 5'd0; wr_data_a = 32'hFFFFFFFF;
    rd_en_a = 2'b11; rd_addr_a = {5'd0, 5'd0};
    step();
    wr_en_a = 1'b0; rd_en_a = 2'b00;
    chk("bypass_r0", rd_data_a, 64'd0);
    read_a(5'd0, 5'd7);
    chk("r0_after", rd_data_a, 64'h12345678_00000000);

    // Fill r1..r31 with index, spot-check
    for (int i = 1; i < 32; i++) write_a(5'(i), 32'(i));
    read_a(5'd1, 5'd31);
    chk("fill_1_31", rd_data_a, 64'h0000001F_00000001);
    read_a(5'd5, 5'd17);
    chk("fill_5_17", rd_data_a, 64'h00000011_00000005);

    // init_req sweep with writes issued during it
    init_req_a = 1'b1;
    step();
    init_req_a = 1'b0;
    wr_en_a = 1'b1; wr_addr_a = 5'd3; wr_data_a = 32'h00000BAD;
    rd_en_a = 2'b11; rd_addr_a = {5'd3, 5'd3};
    count_low_a(n);
    wr_en_a = 1'b0; rd_en_a = 2'b00;
    chk("req_len", 64'(n), 64'd32);
    chk("req_rd_data", rd_data_a, 64'd0);
    chk("req_rd_valid", 64'(rd_valid_a), 64'd0);
    for (int i = 0; i < 32; i += 2) begin
      read_a(5'(i), 5'(i + 1));
      chk("req_clear", rd_data_a, 64'd0);
    end

    // Reset at clear count 10 of a sweep; r20 must be cleared by the restart
    write_a(5'd20, 32'h00000055);
    read_a(5'd20, 5'd20);
    chk("r20_set", rd_data_a, 64'h00000055_00000055);
    init_req_a = 1'b1;
    step();
    init_req_a = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(ready_a), 64'd0);
    chk("midrst_data", rd_data_a, 64'd0);
    step(); step();
    chk("midrst_hold", rd_data_a, 64'd0);
    rst_n = 1'b1;
    count_low_a(n);
    chk("midrst_len", 64'(n), 64'd32);
    read_a(5'd20, 5'd9);
    chk("midrst_r20", rd_data_a, 64'd0);

    // Instance B: ordinary r0, three ports, 8-entry sweep
    step();
    rst_n_b = 1'b1;
    count_low_b(n);
    chk("b_init_len", 64'(n), 64'd8);
    wr_en_b = 1'b1; wr_addr_b = 3'd0; wr_data_b = 8'hA5;
    step();
    wr_en_b = 1'b0;
    rd_en_b = 3'b111; rd_addr_b = {3'd0, 3'd0, 3'd0};
    step();
    rd_en_b = 3'b000;
    chk("b_r0_all", 64'(rd_data_b), 64'hA5A5A5);
    chk("b_valid", 64'(rd_valid_b), 64'd7);
    wr_en_b = 1'b1; wr_addr_b = 3'd0; wr_data_b = 8'h3C;
    rd_en_b = 3'b010; rd_addr_b = {3'd7, 3'd0, 3'd7};
    step();
    wr_en_b = 1'b0; rd_en_b = 3'b000;
    chk("b_bypass_r0", 64'(rd_data_b), 64'hA53CA5);
    chk("b_bypass_valid", 64'(rd_valid_b), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
